// File: rtl/img_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg : frame geometry, scan state encoding and pixel index format.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package img_pkg;

  localparam int IMG_W_SMALL = 640;
  localparam int IMG_H_SMALL = 480;
  localparam int IMG_W_LARGE = 1024;
  localparam int IMG_H_LARGE = 768;
  localparam int IMG_BPP     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } scan_state_t;

  // Same packing the index-to-address converter consumes.
  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } pix_index_t;

endpackage

`default_nettype wire

// File: rtl/img_scan_sequencer.sv
// ----------------------------------------------------------------------------
// img_scan_sequencer : raster-order pixel read request generator.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module img_scan_sequencer
  import img_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = IMG_BPP,
  parameter int FRAME_W0        = IMG_W_SMALL,
  parameter int FRAME_H0        = IMG_H_SMALL,
  parameter int FRAME_W1        = IMG_W_LARGE,
  parameter int FRAME_H1        = IMG_H_LARGE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SIZE_IMAGE,
  input  logic [31:0] BASE_ADDR,
  input  logic        START,
  input  logic        ABORT,
  output logic        REQ_VALID,
  input  logic        REQ_READY,
  output logic [31:0] REQ_ADDR,
  output logic [31:0] REQ_INDEX,
  output logic        REQ_LAST,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [15:0] c_w0_last = 16'(FRAME_W0 - 1);
  localparam logic [15:0] c_h0_last = 16'(FRAME_H0 - 1);
  localparam logic [15:0] c_w1_last = 16'(FRAME_W1 - 1);
  localparam logic [15:0] c_h1_last = 16'(FRAME_H1 - 1);
  localparam logic [31:0] c_step    = 32'(BYTES_PER_PIXEL);

  scan_state_t state_q, state_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [15:0] wlast_q, wlast_d;
  logic [15:0] hlast_q, hlast_d;
  logic [31:0] addr_q, addr_d;

  logic       w_col_end;
  logic       w_frame_end;
  pix_index_t w_index;

  assign w_col_end   = (col_q == wlast_q);
  assign w_frame_end = w_col_end && (row_q == hlast_q);
  assign w_index     = '{row: row_q, col: col_q};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      wlast_q <= '0;
      hlast_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wlast_q <= wlast_d;
      hlast_q <= hlast_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wlast_d = wlast_q;
    hlast_d = hlast_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          addr_d  = BASE_ADDR;
          wlast_d = SIZE_IMAGE ? c_w1_last : c_w0_last;
          hlast_d = SIZE_IMAGE ? c_h1_last : c_h0_last;
        end
      end
      RUN: begin
        // Abort freezes the pointer even if the consumer took the request.
        if (ABORT) begin
          state_d = IDLE;
        end else if (REQ_READY) begin
          addr_d = addr_q + c_step;
          if (w_col_end) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          if (w_frame_end) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign REQ_VALID = (state_q == RUN);
  assign BUSY      = (state_q == RUN);
  assign DONE      = (state_q == FIN);
  assign REQ_LAST  = (state_q == RUN) && w_frame_end;
  assign REQ_ADDR  = addr_q;
  assign REQ_INDEX = w_index;

endmodule

`default_nettype wire

// File: tb/tb_img_scan_sequencer.sv
// ----------------------------------------------------------------------------
// tb_img_scan_sequencer : directed checks of raster scan, stall, abort, reset.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_img_scan_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SIZE_IMAGE = 1'b0;
  logic [31:0] BASE_ADDR = '0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        REQ_READY = 1'b0;
  logic        REQ_VALID;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_INDEX;
  logic        REQ_LAST;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_errors = 0;

  // Full widths keep the row-wrap addresses real; heights shortened for run time.
  img_scan_sequencer #(
    .BYTES_PER_PIXEL(4),
    .FRAME_W0(640),
    .FRAME_H0(3),
    .FRAME_W1(1024),
    .FRAME_H1(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SIZE_IMAGE(SIZE_IMAGE),
    .BASE_ADDR(BASE_ADDR),
    .START(START),
    .ABORT(ABORT),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR),
    .REQ_INDEX(REQ_INDEX),
    .REQ_LAST(REQ_LAST),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts a scan on the current negedge and follows it to DONE or abort.
  task automatic run_scan(input logic size, input logic [31:0] base, input bit rand_ready,
                          input int abort_at, input bit poke_start);
    int          w, h, hs, cyc;
    logic [15:0] row, col;
    logic [31:0] addr;
    bit          fin, last;
    w = size ? 1024 : 640;
    h = size ? 2 : 3;
    SIZE_IMAGE = size;
    BASE_ADDR  = base;
    START      = 1'b1;
    REQ_READY  = 1'b0;
    @(negedge CLK);
    START      = 1'b0;
    SIZE_IMAGE = ~size;
    BASE_ADDR  = 32'hDEAD_BEEC;
    row = '0; col = '0; addr = base; hs = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 20000) begin
      cyc++;
      last = (row == 16'(h - 1)) && (col == 16'(w - 1));
      chk("valid", REQ_VALID, 1);
      chk("busy", BUSY, 1);
      chk("done_in_run", DONE, 0);
      chk("addr", REQ_ADDR, addr);
      chk("index", REQ_INDEX, {row, col});
      chk("last", REQ_LAST, last);
      if (hs == 0) begin
        chk("first_addr", REQ_ADDR, base);
        chk("first_index", REQ_INDEX, 32'h0000_0000);
      end
      if (row == 16'd1 && col == 16'd0) begin
        chk("wrap_index", REQ_INDEX, 32'h0001_0000);
        chk("wrap_addr", REQ_ADDR, base + (size ? 32'h1000 : 32'h0A00));
      end
      if (last) begin
        chk("last_addr", REQ_ADDR, base + (size ? 32'h0000_1FFC : 32'h0000_1DFC));
        chk("last_index", REQ_INDEX, size ? 32'h0001_03FF : 32'h0002_027F);
      end
      START     = (poke_start && hs == 100) ? 1'b1 : 1'b0;
      REQ_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ABORT     = (hs == abort_at) ? 1'b1 : 1'b0;
      if (ABORT) REQ_READY = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      if (ABORT) begin
        ABORT = 1'b0;
        REQ_READY = 1'b0;
        chk("abort_valid", REQ_VALID, 0);
        chk("abort_busy", BUSY, 0);
        for (int i = 0; i < 4; i++) begin
          chk("abort_done", DONE, 0);
          @(negedge CLK);
        end
        fin = 1'b1;
      end else if (REQ_READY) begin
        hs++;
        addr = addr + 32'd4;
        if (last) begin
          REQ_READY = 1'b0;
          chk("handshakes", hs, w * h);
          chk("done_pulse", DONE, 1);
          chk("busy_fin", BUSY, 0);
          chk("valid_fin", REQ_VALID, 0);
          @(negedge CLK);
          chk("done_low", DONE, 0);
          fin = 1'b1;
        end else if (col == 16'(w - 1)) begin
          col = '0;
          row = row + 16'd1;
        end else begin
          col = col + 16'd1;
        end
      end
    end
    chk("scan_timeout", 32'(fin), 1);
  endtask

  initial begin
    #3;
    chk("rst_valid", REQ_VALID, 0);
    chk("rst_addr", REQ_ADDR, 0);
    chk("rst_index", REQ_INDEX, 0);
    chk("rst_last", REQ_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    run_scan(1'b0, 32'h1000_0000, 1'b0, -1, 1'b0);
    run_scan(1'b1, 32'h0000_0000, 1'b0, -1, 1'b0);
    run_scan(1'b0, 32'hFFFF_F800, 1'b1, -1, 1'b0);
    run_scan(1'b0, 32'h1000_0000, 1'b0, 1000, 1'b0);
    run_scan(1'b0, 32'h1000_0000, 1'b0, -1, 1'b0);
    run_scan(1'b1, 32'h2000_0000, 1'b0, -1, 1'b1);

    // Abort wins over a simultaneous start in IDLE.
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    chk("start_abort_valid", REQ_VALID, 0);
    chk("start_abort_busy", BUSY, 0);

    // Asynchronous reset in the middle of a scan.
    SIZE_IMAGE = 1'b0;
    BASE_ADDR  = 32'h3000_0000;
    START      = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
    REQ_READY = 1'b1;
    repeat (50) @(negedge CLK);
    chk("pre_rst_addr", REQ_ADDR, 32'h3000_00C8);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_valid", REQ_VALID, 0);
    chk("midrst_addr", REQ_ADDR, 0);
    chk("midrst_index", REQ_INDEX, 0);
    chk("midrst_last", REQ_LAST, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_done", DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    REQ_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("postrst_done", DONE, 0);
      chk("postrst_valid", REQ_VALID, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
